hazard_sched: RTL
=================

Name: hazard_sched

Overview:
- Central pipeline scheduler for the 5-stage dynamic pipeline.
- Generates the per-stage `condition` codes (FLOW/STALL/ZERO) consumed by the fetch, decode and execute stage registers.
- Generates forwarding selects for decode operands A/B/Rt.
- Sequences the multi-cycle mult/div unit that owns HI/LO, so decode never reads stale HI/LO and never issues over a busy unit.
- Sits beside the decode stage; fed by decode read-address tags and the destination tags of EX/MEM/WB.

Parameters:
- MULT_LAT, 4, cycles from mult issue until HI/LO are written.
- DIV_LAT, 32, cycles from div issue until HI/LO are written.
- TAG_W, 7, width of the register tag: 0-31 GPR, 32 HI, 33 LO, 64-95 CP0, 127 none.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- id_raddr1  in  TAG_W  decode source tag for operand A (Rs/HI/LO/CP0).
- id_raddr2  in  TAG_W  decode source tag for operand B/Rt.
- id_md_start  in  1  decode holds a mult (id_md_div=0) or div (id_md_div=1).
- id_md_div  in  1  selects DIV_LAT vs MULT_LAT.
- id_exc  in  1  decode raises an exception or eret.
- ex_waddr, mem_waddr, wb_waddr  in  TAG_W each  destination tags; 127 means no write.
- ex_is_load  in  1  EX instruction is a load (data available only after MEM).
- cond_if, cond_id, cond_ex  out  2 each  stage condition codes.
- fwd_a, fwd_b, fwd_rt  out  2 each  0 = register file, 1 = EX, 2 = MEM, 3 = WB.
- md_busy  out  1  mult/div unit occupied.
- md_done  out  1  one-cycle pulse: HI/LO write this cycle.

Behaviour:
- Encodings: COND_FLOW=2'b00, COND_STALL=2'b01, COND_ZERO=2'b10.
- Reset (synchronous): cond_* = FLOW, fwd_* = 0, md_busy=0, md_done=0, counter=0, FSM=RUN.
- Forwarding (combinational):
  - Match a source tag against ex_waddr, then mem_waddr, then wb_waddr; youngest match wins.
  - Tags 0 and 127 never match.
  - fwd_rt uses id_raddr2, as fwd_b does.
- Load-use hazard: ex_is_load and ex_waddr matches a source (not 0/127) gives cond_if=STALL, cond_id=ZERO (bubble into EX), cond_ex=FLOW, for exactly 1 cycle.
- HI/LO hazard: a source tag of 32/33 while md_busy gives cond_if=STALL, cond_id=ZERO until the cycle md_done is high. In that cycle the unit still reports busy for the read; decode is released the cycle after md_done.
- Structural: id_md_start while md_busy stalls the same way until md_busy falls.
- Mult/div counter:
  - On id_md_start with cond_id=FLOW, load MULT_LAT-1 or DIV_LAT-1 and set md_busy next cycle.
  - Decrement each cycle while busy. md_done=1 when the counter=0 and busy; busy clears the same edge.
  - The counter is never aborted by a flush.
- FSM states RUN, FLUSH:
  - RUN to FLUSH when id_exc=1 and decode flows.
  - In FLUSH, cond_if=ZERO for one cycle (kills the wrong-path fetch), then return to RUN.
  - cond_id/cond_ex=FLOW in FLUSH unless a stall condition is active.
- Priority: rst > FLUSH > load-use > HI/LO/structural stall > FLOW.
  - A stall and id_exc in the same cycle: the stall wins. id_exc is re-evaluated when decode flows.
- Reset mid-divide: counter and busy cleared immediately; no md_done pulse.
- Latency: cond_* and fwd_* are combinational from inputs and registered state; no added pipeline delay.

Decomposition:
- Shared package/header `pipe_defs`: COND_FLOW/STALL/ZERO, IR_NON, tag constants TAG_HI=32, TAG_LO=33, TAG_CP0_BASE=64, TAG_NONE=127, fwd select codes.
- One sub-module `md_counter`: load, decrement, busy and done pulse, parameterised by MULT_LAT/DIV_LAT.
- Forwarding compare stays inline.

Test Plan:
- Forward priority:
  - Stimulus: id_raddr1=5, ex_waddr=5, mem_waddr=5, ex_is_load=0.
  - Required: fwd_a=1, all conds FLOW. With ex_waddr=127: fwd_a=2. With tag 0 everywhere: fwd_a=0.
- Load-use:
  - Stimulus: ex_is_load=1, ex_waddr=8, id_raddr2=8.
  - Required: for one cycle cond_if=STALL, cond_id=ZERO. Next cycle (load in MEM, mem_waddr=8): FLOW with fwd_b=2.
- Divide sequencing:
  - Stimulus: id_md_start=1, id_md_div=1, then id_raddr1=33 on the next instruction.
  - Required: md_busy high 32 cycles, md_done pulses on cycle 32, stall held throughout, release the following cycle.
- Back-to-back mult:
  - Stimulus: two id_md_start cycles consecutively.
  - Required: second stalled exactly until md_busy falls (4 cycles), then issued; second md_done 4 cycles later.
- Exception flush:
  - Stimulus: id_exc=1 with no hazards.
  - Required: next cycle cond_if=ZERO, then FLOW. With id_exc during load-use stall: no flush until the stall clears.
- Reset mid-divide:
  - Stimulus: assert rst at busy cycle 10.
  - Required: next edge md_busy=0, md_done never pulses, all cond=FLOW.

Source files
------------

// File: rtl/hazard_sched_pkg.sv
// Shared pipeline definitions: stage condition codes, forwarding selects and register tag map.
package hazard_sched_pkg;

    typedef enum logic [1:0] {
        CondFlow  = 2'b00,
        CondStall = 2'b01,
        CondZero  = 2'b10
    } cond_e;

    typedef enum logic [1:0] {
        FwdRf  = 2'd0,
        FwdEx  = 2'd1,
        FwdMem = 2'd2,
        FwdWb  = 2'd3
    } fwd_e;

    typedef enum logic {
        StRun,
        StFlush
    } sched_st_e;

    localparam int unsigned TagWidth   = 7;
    localparam int unsigned TagHi      = 32;
    localparam int unsigned TagLo      = 33;
    localparam int unsigned TagCp0Base = 64;
    localparam int unsigned TagNone    = 127;

    // Instruction word injected by a zeroed stage register.
    localparam logic [31:0] IrNon = 32'h0000_0000;

endpackage

// File: rtl/md_counter.sv
// Mult/div occupancy counter: loads the unit latency on issue, counts down, pulses done on the
// cycle HI/LO are written and drops busy on that same edge.
module md_counter #(
    parameter int unsigned MultLat = 4,
    parameter int unsigned DivLat  = 32
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic start_i,
    input  logic div_i,
    output logic busy_o,
    output logic done_o
);

    localparam int unsigned MaxLat = (DivLat > MultLat) ? DivLat : MultLat;
    localparam int unsigned CntW   = (MaxLat > 2) ? $clog2(MaxLat) : 1;

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            busy_q, busy_d;

    always_comb begin
        cnt_d  = cnt_q;
        busy_d = busy_q;
        done_o = 1'b0;
        if (busy_q) begin
            if (cnt_q == '0) begin
                done_o = 1'b1;
                busy_d = 1'b0;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end
        if (start_i) begin
            cnt_d  = div_i ? CntW'(DivLat - 1) : CntW'(MultLat - 1);
            busy_d = 1'b1;
        end
        // A reset landing mid-operation must not leak a done pulse.
        if (rst_i) begin
            done_o = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
        end
    end

    assign busy_o = busy_q;

endmodule

// File: rtl/hazard_sched.sv
// Central pipeline scheduler: stage conditions, decode operand forwarding and mult/div
// sequencing so decode never reads stale HI/LO or issues over a busy unit.
module hazard_sched
    import hazard_sched_pkg::*;
#(
    parameter int unsigned MultLat = 4,
    parameter int unsigned DivLat  = 32,
    parameter int unsigned TagW    = TagWidth
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [TagW-1:0] id_raddr1_i,
    input  logic [TagW-1:0] id_raddr2_i,
    input  logic            id_md_start_i,
    input  logic            id_md_div_i,
    input  logic            id_exc_i,
    input  logic [TagW-1:0] ex_waddr_i,
    input  logic [TagW-1:0] mem_waddr_i,
    input  logic [TagW-1:0] wb_waddr_i,
    input  logic            ex_is_load_i,
    output logic [1:0]      cond_if_o,
    output logic [1:0]      cond_id_o,
    output logic [1:0]      cond_ex_o,
    output logic [1:0]      fwd_a_o,
    output logic [1:0]      fwd_b_o,
    output logic [1:0]      fwd_rt_o,
    output logic            md_busy_o,
    output logic            md_done_o
);

    sched_st_e state_q, state_d;
    logic      md_busy, md_done, md_start;
    logic      load_use, hilo_use, md_struct, stall;

    function automatic logic tag_live(input logic [TagW-1:0] t);
        return (t != '0) && (t != TagW'(TagNone));
    endfunction

    function automatic logic tag_hilo(input logic [TagW-1:0] t);
        return (t == TagW'(TagHi)) || (t == TagW'(TagLo));
    endfunction

    // Youngest producer wins: EX, then MEM, then WB.
    function automatic fwd_e fwd_sel(input logic [TagW-1:0] src, input logic [TagW-1:0] ex,
                                     input logic [TagW-1:0] mem, input logic [TagW-1:0] wb);
        if (!tag_live(src)) return FwdRf;
        if (src == ex)      return FwdEx;
        if (src == mem)     return FwdMem;
        if (src == wb)      return FwdWb;
        return FwdRf;
    endfunction

    always_comb begin
        load_use  = ex_is_load_i && tag_live(ex_waddr_i) &&
                    ((ex_waddr_i == id_raddr1_i) || (ex_waddr_i == id_raddr2_i));
        hilo_use  = md_busy && (tag_hilo(id_raddr1_i) || tag_hilo(id_raddr2_i));
        md_struct = id_md_start_i && md_busy;
        stall     = load_use || hilo_use || md_struct;

        cond_if_o = CondFlow;
        cond_id_o = CondFlow;
        cond_ex_o = CondFlow;
        fwd_a_o   = FwdRf;
        fwd_b_o   = FwdRf;
        fwd_rt_o  = FwdRf;
        md_start  = 1'b0;
        state_d   = StRun;

        if (!rst_i) begin
            fwd_a_o  = fwd_sel(id_raddr1_i, ex_waddr_i, mem_waddr_i, wb_waddr_i);
            fwd_b_o  = fwd_sel(id_raddr2_i, ex_waddr_i, mem_waddr_i, wb_waddr_i);
            fwd_rt_o = fwd_b_o;

            if (state_q == StFlush) begin
                cond_if_o = CondZero;
            end else if (stall) begin
                cond_if_o = CondStall;
            end
            // A stalled decode bubbles into EX; the EX stage itself always advances.
            if (stall) begin
                cond_id_o = CondZero;
            end

            md_start = id_md_start_i && !stall;
            if ((state_q == StRun) && id_exc_i && !stall) begin
                state_d = StFlush;
            end
        end
    end

    md_counter #(
        .MultLat(MultLat),
        .DivLat (DivLat)
    ) u_md_counter (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .start_i(md_start),
        .div_i  (id_md_div_i),
        .busy_o (md_busy),
        .done_o (md_done)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StRun;
        end else begin
            state_q <= state_d;
        end
    end

    assign md_busy_o = md_busy;
    assign md_done_o = md_done;

endmodule
